// File: rtl/biasamp_trim_ctrl_if.sv
// Signal bundle between the bias-amp trim sequencer and its control/analog side.
// The slave modport is the sequencer's view of the bundle.
interface biasamp_trim_ctrl_if #(
    parameter int TRIM_W = 6
) ();
    logic              start;
    logic              abort;
    logic              man_en;
    logic [TRIM_W-1:0] man_trim;
    logic              cmp_in;
    logic [TRIM_W-1:0] trim;
    logic              cal_en;
    logic              busy;
    logic              done;
    logic              cal_ok;

    modport master (
        output start, abort, man_en, man_trim, cmp_in,
        input  trim, cal_en, busy, done, cal_ok
    );

    modport slave (
        input  start, abort, man_en, man_trim, cmp_in,
        output trim, cal_en, busy, done, cal_ok
    );
endinterface

// File: rtl/biasamp_trim_ctrl.sv
// SAR offset-trim calibration sequencer for the on-chip bias amplifier.
// Binary-searches the trim code from the synchronised comparator, with manual override and abort.
module biasamp_trim_ctrl #(
    parameter int TRIM_W      = 6,
    parameter int SETTLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    biasamp_trim_ctrl_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [TRIM_W-1:0] ALL_ONES = {TRIM_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    cmp_s;
    logic [TRIM_W-1:0]       trim_r;
    logic [TRIM_W-1:0]       saved_r;
    logic [TRIM_W-1:0]       sample_trim_s;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    cal_en_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    cal_ok_r;

    // A result pinned at either rail means the trim range could not reach the offset.
    function automatic logic trim_ok(input logic [TRIM_W-1:0] t);
        return (t != {TRIM_W{1'b0}}) && (t != ALL_ONES);
    endfunction

    // Comparator crosses from the analog domain; the FSM only ever sees cmp_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.cmp_in};
        end
    end

    assign cmp_s = sync_r[SYNC_STAGES-1];

    // SAR step: drop the bit under test if the amp reads high, then trial the next bit down.
    always_comb begin
        sample_trim_s        = trim_r;
        sample_trim_s[idx_r] = trim_r[idx_r] & ~cmp_s;
        if (idx_r != IDX_W'(0)) begin
            sample_trim_s[idx_r - IDX_W'(1)] = 1'b1;
        end else begin
            sample_trim_s[0] = trim_r[0] & ~cmp_s;
        end
    end

    // Calibration sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            trim_r   <= MIDSCALE;
            saved_r  <= MIDSCALE;
            idx_r    <= '0;
            cnt_r    <= '0;
            cal_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cal_ok_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.man_en) begin
                        trim_r <= bus.man_trim;
                    end else if (bus.start && !bus.abort) begin
                        saved_r  <= trim_r;
                        trim_r   <= MIDSCALE;
                        idx_r    <= IDX_W'(TRIM_W - 1);
                        cnt_r    <= CNT_W'(SETTLE_CYC - 1);
                        cal_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                        cal_ok_r <= 1'b0;
                        state_r  <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        trim_r   <= saved_r;
                        cal_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (cnt_r == CNT_W'(0)) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        trim_r   <= saved_r;
                        cal_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (idx_r != IDX_W'(0)) begin
                        trim_r  <= sample_trim_s;
                        idx_r   <= idx_r - IDX_W'(1);
                        cnt_r   <= CNT_W'(SETTLE_CYC - 1);
                        state_r <= ST_SETTLE;
                    end else begin
                        trim_r   <= sample_trim_s;
                        cal_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r   <= 1'b0;
                    cal_ok_r <= trim_ok(trim_r);
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cal_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trim   = trim_r;
    assign bus.cal_en = cal_en_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.cal_ok = cal_ok_r;
endmodule
